// File: rtl/scc_mem_pkg.sv
// Shared encodings for the SCC memory arbiter.
// Holds FSM state, request source and counter width.
package scc_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    localparam int CNT_W = 4;

endpackage

// File: rtl/scc_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: req_inst_i, req_data_i, last_i (last served source)
//        -> gnt_o one-hot {data, inst}.
module scc_rr_arb2
    import scc_mem_pkg::*;
(
    input  logic       req_inst_i,
    input  logic       req_data_i,
    input  src_e       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_inst_i && req_data_i) begin
            // tie: serve whichever side was not served last
            gnt_o = (last_i == SRC_DATA) ? 2'b01 : 2'b10;
        end else begin
            gnt_o = {req_data_i, req_inst_i};
        end
    end

endmodule

// File: rtl/scc_mem_arbiter.sv
// Merges SCC fetch and data ports onto one fixed-latency sync memory.
// Ports: clk/reset; fetch in_mem_*; data data_*; memory mem_*.
module scc_mem_arbiter
    import scc_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_mem_addr,
    input  logic              in_mem_en,
    output logic [DATA_W-1:0] in_mem,
    output logic              in_mem_valid,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_out,
    input  logic              data_read,
    input  logic              data_write,
    output logic [DATA_W-1:0] data_in,
    output logic              data_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("scc_mem_arbiter: WAIT_CYCLES must be 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    src_e              src_q, src_d;
    src_e              last_q, last_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] in_mem_q, in_mem_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;

    logic       req_data;
    src_e       arb_last;
    logic [1:0] gnt;

    assign req_data = data_read | data_write;

    // Until the first completion, present INST as last so the
    // opening tie goes to data.
    assign arb_last = first_q ? SRC_INST : last_q;

    scc_rr_arb2 u_arb (
        .req_inst_i (in_mem_en),
        .req_data_i (req_data),
        .last_i     (arb_last),
        .gnt_o      (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_q      <= 1'b0;
            src_q     <= SRC_INST;
            last_q    <= SRC_DATA;
            first_q   <= 1'b1;
            in_mem_q  <= '0;
            data_in_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wr_q      <= wr_d;
            src_q     <= src_d;
            last_q    <= last_d;
            first_q   <= first_d;
            in_mem_q  <= in_mem_d;
            data_in_q <= data_in_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_d      = wr_q;
        src_d     = src_q;
        last_d    = last_q;
        first_d   = first_q;
        in_mem_d  = in_mem_q;
        data_in_d = data_in_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_INIT;
                    if (gnt[1]) begin
                        src_d   = SRC_DATA;
                        addr_d  = data_addr;
                        wdata_d = data_out;
                        // read+write together is a write
                        wr_d    = data_write;
                    end else begin
                        src_d   = SRC_INST;
                        addr_d  = in_mem_addr;
                        wr_d    = 1'b0;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!wr_q) begin
                        if (src_q == SRC_DATA) begin
                            data_in_d = mem_rdata;
                        end else begin
                            in_mem_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                last_d  = src_q;
                first_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes and valids decode straight from state so an async
    // reset drops them in the same cycle.
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_re       = (state_q == ST_ACCESS) && !wr_q;
    assign mem_we       = (state_q == ST_ACCESS) && wr_q;
    assign in_mem_valid = (state_q == ST_DONE) && (src_q == SRC_INST);
    assign data_valid   = (state_q == ST_DONE) && (src_q == SRC_DATA);
    assign in_mem       = in_mem_q;
    assign data_in      = data_in_q;

endmodule

// File: tb/tb_scc_mem_arbiter.sv
// Self-checking bench for scc_mem_arbiter.
// Two instances: WAIT_CYCLES=1 and WAIT_CYCLES=3.
module tb_scc_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // W=1 instance
    logic        r1, ie1, dr1, dw1, imv1, dv1, re1, we1;
    logic [31:0] ia1, da1, dd1, im1, di1, ma1, mw1, rd1;
    // W=3 instance
    logic        r3, ie3, dr3, dw3, imv3, dv3, re3, we3;
    logic [31:0] ia3, da3, dd3, im3, di3, ma3, mw3, rd3;

    logic [31:0] m1 [0:255] = '{4: 32'hE3A00001, default: 32'h0};
    logic [31:0] m3 [0:255] = '{4: 32'hE3A00001, default: 32'h0};

    always @(posedge clk) if (we1) m1[ma1[9:2]] <= mw1;
    always @(posedge clk) if (we3) m3[ma3[9:2]] <= mw3;
    always_comb rd1 = m1[ma1[9:2]];
    always_comb rd3 = m3[ma3[9:2]];

    scc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(r1),
        .in_mem_addr(ia1), .in_mem_en(ie1), .in_mem(im1), .in_mem_valid(imv1),
        .data_addr(da1), .data_out(dd1), .data_read(dr1), .data_write(dw1),
        .data_in(di1), .data_valid(dv1),
        .mem_addr(ma1), .mem_wdata(mw1), .mem_re(re1), .mem_we(we1),
        .mem_rdata(rd1)
    );

    scc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(r3),
        .in_mem_addr(ia3), .in_mem_en(ie3), .in_mem(im3), .in_mem_valid(imv3),
        .data_addr(da3), .data_out(dd3), .data_read(dr3), .data_write(dw3),
        .data_in(di3), .data_valid(dv3),
        .mem_addr(ma3), .mem_wdata(mw3), .mem_re(re3), .mem_we(we3),
        .mem_rdata(rd3)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input bit w3, input bit ie, input bit rd,
                         input bit wr, input logic [31:0] a,
                         input logic [31:0] wd);
        if (w3) begin
            ie3 = ie; dr3 = rd; dw3 = wr; ia3 = a; da3 = a; dd3 = wd;
        end else begin
            ie1 = ie; dr1 = rd; dw1 = wr; ia1 = a; da1 = a; dd1 = wd;
        end
    endtask

    // Issue one request in IDLE, hold until valid, then drop it.
    task automatic txn(input bit w3, input bit d, input bit rd,
                       input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output int lat,
                       output int nre, output int nwe,
                       output logic [31:0] res);
        bit v;
        lat = 0; nre = 0; nwe = 0; res = '0; v = 1'b0;
        drive(w3, !d, d & rd, d & wr, a, wd);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); @(negedge clk);
            lat = i;
            if (w3) begin
                nre += int'(re3); nwe += int'(we3);
                v = imv3 | dv3; res = d ? di3 : im3;
            end else begin
                nre += int'(re1); nwe += int'(we1);
                v = imv1 | dv1; res = d ? di1 : im1;
            end
            if (v) break;
        end
        drive(w3, 1'b0, 1'b0, 1'b0, a, wd);
        @(posedge clk); @(negedge clk);
    endtask

    typedef struct {
        bit          d;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp;
        int          ere;
        int          ewe;
    } vec_t;

    vec_t tv [8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    initial begin : main
        int lat, nre, nwe, nv, nr;
        logic [31:0] res;
        bit prev_v, cur_v;
        int ev_src [4];
        int ev_cyc [4];
        logic [31:0] ev_dat [4];
        int nev;

        tv[0] = '{1'b1, 1'b0, 1'b1, 32'h100, 32'h11112222, 32'h0, 0, 1};
        tv[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h11112222, 1, 0};
        tv[2] = '{1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h11112222, 1, 0};
        tv[3] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 32'h11112222, 0, 1};
        tv[4] = '{1'b0, 1'b0, 1'b0, 32'h104, 32'h0, 32'hCAFEF00D, 1, 0};
        tv[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 32'hE3A00001, 1, 0};
        tv[6] = '{1'b1, 1'b1, 1'b1, 32'h40, 32'h55, 32'hE3A00001, 0, 1};
        tv[7] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h00000055, 1, 0};

        r1 = 1'b1; r3 = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_w1_ctl", {28'h0, imv1, dv1, re1, we1}, 32'h0);
        chk("rst_w1_dat", im1 | di1 | ma1 | mw1, 32'h0);
        chk("rst_w3_ctl", {28'h0, imv3, dv3, re3, we3}, 32'h0);
        @(negedge clk);
        r1 = 1'b0; r3 = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("idle_w1_ctl", {28'h0, imv1, dv1, re1, we1}, 32'h0);

        // Scenario 1: single fetch, W=1
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("s1_c1_re", {31'h0, re1}, 32'h1);
        chk("s1_c1_addr", ma1, 32'h10);
        chk("s1_c1_valid", {31'h0, imv1}, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("s1_c2_valid", {31'h0, imv1}, 32'h1);
        chk("s1_c2_re", {31'h0, re1}, 32'h0);
        chk("s1_c2_inst", im1, 32'hE3A00001);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("s1_c3_valid", {31'h0, imv1}, 32'h0);

        // Table vectors on W=1
        for (int k = 0; k < 8; k++) begin
            txn(1'b0, tv[k].d, tv[k].rd, tv[k].wr, tv[k].addr, tv[k].wd,
                lat, nre, nwe, res);
            chk($sformatf("tv%0d_lat", k), lat, 2);
            chk($sformatf("tv%0d_nre", k), nre, tv[k].ere);
            chk($sformatf("tv%0d_nwe", k), nwe, tv[k].ewe);
            chk($sformatf("tv%0d_res", k), res, tv[k].exp);
        end

        // Scenario 2: write then read-back, W=3
        txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, lat, nre, nwe, res);
        chk("s2_wr_lat", lat, 4);
        chk("s2_wr_nwe", nwe, 3);
        chk("s2_wr_nre", nre, 0);
        txn(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, lat, nre, nwe, res);
        chk("s2_rd_lat", lat, 4);
        chk("s2_rd_nre", nre, 3);
        chk("s2_rd_data", res, 32'hDEADBEEF);

        // Scenario 5: reset in 2nd ACCESS cycle, W=3
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(posedge clk); @(negedge clk);
        chk("s5_acc1_re", {31'h0, re3}, 32'h1);
        @(posedge clk);
        #1 r3 = 1'b1;
        #1;
        chk("s5_rst_ctl", {28'h0, imv3, dv3, re3, we3}, 32'h0);
        chk("s5_rst_addr", ma3, 32'h0);
        chk("s5_rst_din", di3, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nv += int'(imv3 | dv3 | re3);
        end
        chk("s5_quiet", nv, 0);
        r3 = 1'b0;
        txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, nre, nwe, res);
        chk("s5_after_lat", lat, 4);
        chk("s5_after_nre", nre, 3);
        chk("s5_after_inst", res, 32'hE3A00001);

        // Scenario 3: both requests held from reset, W=3
        r3 = 1'b1;
        ie3 = 1'b1; ia3 = 32'h10;
        dr3 = 1'b1; dw3 = 1'b0; da3 = 32'h200; dd3 = 32'h0;
        @(negedge clk);
        r3 = 1'b0;
        nev = 0; prev_v = 1'b0; nr = 0;
        for (int c = 1; c <= 40 && nev < 4; c++) begin
            @(posedge clk); @(negedge clk);
            cur_v = imv3 | dv3;
            if (imv3 & dv3) nr++;
            if (cur_v & prev_v) nr++;
            if (cur_v) begin
                ev_src[nev] = int'(dv3);
                ev_cyc[nev] = c;
                ev_dat[nev] = dv3 ? di3 : im3;
                nev++;
            end
            prev_v = cur_v;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("s3_count", nev, 4);
        chk("s3_bad_pulse", nr, 0);
        if (nev == 4) begin
            chk("s3_first_cyc", ev_cyc[0], 4);
            for (int e = 0; e < 4; e++) begin
                chk($sformatf("s3_src%0d", e), ev_src[e], (e % 2 == 0) ? 1 : 0);
                chk($sformatf("s3_dat%0d", e), ev_dat[e],
                    (e % 2 == 0) ? 32'hDEADBEEF : 32'hE3A00001);
            end
            for (int e = 1; e < 4; e++)
                chk($sformatf("s3_gap%0d", e), ev_cyc[e] - ev_cyc[e-1], 5);
        end
        @(posedge clk); @(negedge clk);

        // Scenario 6: fetch held continuously, W=3
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        nv = 0; nr = 0; nre = 0; prev_v = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); @(negedge clk);
            cur_v = imv3;
            nv += int'(cur_v);
            nre += int'(re3);
            if (cur_v & prev_v) nr++;
            prev_v = cur_v;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        chk("s6_valids", nv, 3);
        chk("s6_re_cycles", nre, 9);
        chk("s6_wide", nr, 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
